// File: rtl/frogger_life_if.sv
// -----------------------------------------------------------------------------
// frogger_life_if
// Groups the game-flow inputs and the life/status outputs of the life manager.
//   Requests  : i_Start (restart pulse), i_Collided (hit level),
//               i_Goal_Reached (goal pulse)
//   Status    : o_Lives[1:0], o_Wins[3:0], o_Respawn, o_Freeze,
//               o_Invulnerable, o_Game_Over
// master drives the requests and observes status; slave is the life manager.
// -----------------------------------------------------------------------------
interface frogger_life_if;
    logic       i_Start;
    logic       i_Collided;
    logic       i_Goal_Reached;
    logic [1:0] o_Lives;
    logic [3:0] o_Wins;
    logic       o_Respawn;
    logic       o_Freeze;
    logic       o_Invulnerable;
    logic       o_Game_Over;

    modport master (
        output i_Start, i_Collided, i_Goal_Reached,
        input  o_Lives, o_Wins, o_Respawn, o_Freeze, o_Invulnerable, o_Game_Over
    );

    modport slave (
        input  i_Start, i_Collided, i_Goal_Reached,
        output o_Lives, o_Wins, o_Respawn, o_Freeze, o_Invulnerable, o_Game_Over
    );
endinterface

// File: rtl/frogger_life_manager.sv
// -----------------------------------------------------------------------------
// frogger_life_manager
// Owns the life count and sequences hit -> freeze (DYING) -> respawn ->
// grace (invulnerable) -> play, plus game over and start/restart.
// Ports:
//   i_Clk    system clock
//   i_Rst_n  asynchronous active-low reset
//   bus      frogger_life_if.slave: i_Start, i_Collided, i_Goal_Reached in;
//            o_Lives, o_Wins, o_Respawn, o_Freeze, o_Invulnerable,
//            o_Game_Over out (all registered)
// -----------------------------------------------------------------------------
module frogger_life_manager #(
    parameter int LIVES_INIT     = 3,
    parameter int RESPAWN_CYCLES = 25_000_000,
    parameter int GRACE_CYCLES   = 50_000_000
) (
    input  logic           i_Clk,
    input  logic           i_Rst_n,
    frogger_life_if.slave  bus
);
    localparam int MAX_CYC = (RESPAWN_CYCLES > GRACE_CYCLES) ? RESPAWN_CYCLES : GRACE_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] RESPAWN_LOAD = CNT_W'(RESPAWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GRACE_LOAD   = CNT_W'(GRACE_CYCLES - 1);
    localparam logic [1:0]       LIVES_LOAD   = 2'(LIVES_INIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_DYING,
        S_GRACE,
        S_GAME_OVER
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // A goal is only honoured when no respawn pulse is currently out: the frog
    // has just been put back at the origin, so a goal in that cycle cannot be
    // genuine, and this keeps o_Respawn from ever being high two cycles in a row.
    logic goal_ok;
    assign goal_ok = bus.i_Goal_Reached && !bus.o_Respawn;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state              <= S_IDLE;
            cnt                <= '0;
            bus.o_Lives        <= LIVES_LOAD;
            bus.o_Wins         <= 4'd0;
            bus.o_Respawn      <= 1'b0;
            bus.o_Freeze       <= 1'b1;
            bus.o_Invulnerable <= 1'b0;
            bus.o_Game_Over    <= 1'b0;
        end else begin
            bus.o_Respawn <= 1'b0;

            case (state)
                S_IDLE, S_GAME_OVER: begin
                    if (bus.i_Start) begin
                        state              <= S_PLAY;
                        bus.o_Lives        <= LIVES_LOAD;
                        bus.o_Wins         <= 4'd0;
                        bus.o_Respawn      <= 1'b1;
                        bus.o_Freeze       <= 1'b0;
                        bus.o_Invulnerable <= 1'b0;
                        bus.o_Game_Over    <= 1'b0;
                    end
                end

                S_PLAY: begin
                    if (bus.i_Collided) begin
                        // Collision takes priority; a simultaneous goal is dropped.
                        bus.o_Freeze <= 1'b1;
                        if (bus.o_Lives > 2'd1) begin
                            state       <= S_DYING;
                            bus.o_Lives <= bus.o_Lives - 2'd1;
                            cnt         <= RESPAWN_LOAD;
                        end else begin
                            state           <= S_GAME_OVER;
                            bus.o_Lives     <= 2'd0;
                            bus.o_Game_Over <= 1'b1;
                        end
                    end else if (goal_ok) begin
                        if (bus.o_Wins != 4'd15)
                            bus.o_Wins <= bus.o_Wins + 4'd1;
                        bus.o_Respawn <= 1'b1;
                    end
                end

                S_DYING: begin
                    if (cnt == '0) begin
                        state              <= S_GRACE;
                        cnt                <= GRACE_LOAD;
                        bus.o_Respawn      <= 1'b1;
                        bus.o_Freeze       <= 1'b0;
                        bus.o_Invulnerable <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_GRACE: begin
                    if (goal_ok) begin
                        if (bus.o_Wins != 4'd15)
                            bus.o_Wins <= bus.o_Wins + 4'd1;
                        bus.o_Respawn <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state              <= S_PLAY;
                        bus.o_Invulnerable <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    bus.o_Freeze <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frogger_life_manager.sv
// -----------------------------------------------------------------------------
// tb_frogger_life_manager
// Directed walk through the game flow followed by a randomized run, with a
// behavioural model tracking lives, wins and remaining freeze/grace time.
// -----------------------------------------------------------------------------
module tb_frogger_life_manager;
    localparam int LIVES  = 3;
    localparam int RESP_N = 4;
    localparam int GRACE_N = 6;

    logic i_Clk = 1'b0;
    logic i_Rst_n = 1'b0;

    frogger_life_if lif ();

    frogger_life_manager #(
        .LIVES_INIT     (LIVES),
        .RESPAWN_CYCLES (RESP_N),
        .GRACE_CYCLES   (GRACE_N)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .bus     (lif.slave)
    );

    always #5 i_Clk = ~i_Clk;

    int checks = 0;
    int errors = 0;

    // Model: game is "active" between start and game over; freezing and grace
    // are represented as remaining-cycle budgets.
    int m_active, m_go, m_lives, m_wins, m_dying_left, m_grace_left, m_resp;

    task automatic model_reset();
        m_active = 0; m_go = 0; m_lives = LIVES; m_wins = 0;
        m_dying_left = 0; m_grace_left = 0; m_resp = 0;
    endtask

    task automatic model_step(input int s, input int c, input int g);
        int prev_resp;
        prev_resp = m_resp;
        m_resp = 0;
        if (!m_active) begin
            if (s != 0) begin
                m_active = 1; m_go = 0; m_lives = LIVES; m_wins = 0; m_resp = 1;
            end
        end else if (m_dying_left > 0) begin
            m_dying_left--;
            if (m_dying_left == 0) begin
                m_grace_left = GRACE_N;
                m_resp = 1;
            end
        end else begin
            if (c != 0 && m_grace_left == 0) begin
                if (m_lives > 1) begin
                    m_lives--;
                    m_dying_left = RESP_N;
                end else begin
                    m_lives = 0; m_active = 0; m_go = 1;
                end
            end else if (g != 0 && prev_resp == 0) begin
                m_wins = (m_wins < 15) ? m_wins + 1 : 15;
                m_resp = 1;
            end
            if (m_grace_left > 0) m_grace_left--;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".lives"}, 32'(lif.o_Lives), m_lives);
        chk({tag, ".wins"},  32'(lif.o_Wins), m_wins);
        chk({tag, ".resp"},  32'(lif.o_Respawn), m_resp);
        chk({tag, ".freeze"}, 32'(lif.o_Freeze), (m_active == 0 || m_dying_left > 0) ? 1 : 0);
        chk({tag, ".inv"},   32'(lif.o_Invulnerable), (m_grace_left > 0) ? 1 : 0);
        chk({tag, ".go"},    32'(lif.o_Game_Over), m_go);
    endtask

    // Apply inputs for one clock, advance the model, check #1 after the edge.
    task automatic step(input string tag, input logic s, input logic c, input logic g);
        lif.i_Start = s; lif.i_Collided = c; lif.i_Goal_Reached = g;
        @(posedge i_Clk);
        model_step(int'(s), int'(c), int'(g));
        #1;
        lif.i_Start = 1'b0; lif.i_Collided = 1'b0; lif.i_Goal_Reached = 1'b0;
        chk_model(tag);
    endtask

    initial begin
        lif.i_Start = 1'b0; lif.i_Collided = 1'b0; lif.i_Goal_Reached = 1'b0;
        model_reset();
        repeat (3) @(negedge i_Clk);
        i_Rst_n = 1'b1;
        #1;
        chk("reset.lives", 32'(lif.o_Lives), 3);
        chk("reset.freeze", 32'(lif.o_Freeze), 1);
        chk_model("reset");
        step("idle", 0, 0, 0);

        // Start
        step("start", 1, 0, 0);
        chk("start.resp", 32'(lif.o_Respawn), 1);
        chk("start.freeze", 32'(lif.o_Freeze), 0);
        chk("start.wins", 32'(lif.o_Wins), 0);
        step("play", 0, 0, 0);
        step("play", 0, 0, 0);

        // First hit: 4 frozen cycles, respawn, 6 grace cycles
        step("hit1", 0, 1, 0);
        chk("hit1.lives", 32'(lif.o_Lives), 2);
        chk("hit1.freeze", 32'(lif.o_Freeze), 1);
        for (int i = 0; i < 3; i++) begin
            step("dying", 0, 0, 0);
            chk("dying.freeze", 32'(lif.o_Freeze), 1);
        end
        step("respawn", 0, 0, 0);
        chk("respawn.resp", 32'(lif.o_Respawn), 1);
        chk("respawn.inv", 32'(lif.o_Invulnerable), 1);
        chk("respawn.freeze", 32'(lif.o_Freeze), 0);
        step("grace_hit", 0, 1, 0);
        chk("grace_hit.lives", 32'(lif.o_Lives), 2);
        for (int i = 0; i < 4; i++) begin
            step("grace", 0, 0, 0);
            chk("grace.inv", 32'(lif.o_Invulnerable), 1);
        end
        step("grace_end", 0, 0, 0);
        chk("grace_end.inv", 32'(lif.o_Invulnerable), 0);

        // Collision and goal together: collision wins
        step("col_goal", 0, 1, 1);
        chk("col_goal.lives", 32'(lif.o_Lives), 1);
        chk("col_goal.wins", 32'(lif.o_Wins), 0);
        for (int i = 0; i < 11; i++) step("recover", 0, 0, 0);

        // Last life
        step("hit3", 0, 1, 0);
        chk("hit3.lives", 32'(lif.o_Lives), 0);
        chk("hit3.go", 32'(lif.o_Game_Over), 1);
        step("gameover", 0, 1, 1);
        step("restart", 1, 0, 0);
        chk("restart.lives", 32'(lif.o_Lives), 3);
        chk("restart.go", 32'(lif.o_Game_Over), 0);
        chk("restart.wins", 32'(lif.o_Wins), 0);
        step("play", 0, 0, 0);

        // 17 goals: saturate at 15, one respawn pulse each
        for (int k = 1; k <= 17; k++) begin
            step("goal", 0, 0, 1);
            chk("goal.resp", 32'(lif.o_Respawn), 1);
            chk("goal.wins", 32'(lif.o_Wins), (k > 15) ? 15 : k);
            step("goal_gap", 0, 0, 0);
        end
        step("start_in_play", 1, 0, 0);
        chk("start_in_play.wins", 32'(lif.o_Wins), 15);

        // Hit, start during DYING (ignored), then async reset with counter=2
        step("hit_r", 0, 1, 0);
        step("start_dying", 1, 0, 0);
        chk("start_dying.freeze", 32'(lif.o_Freeze), 1);
        chk("start_dying.lives", 32'(lif.o_Lives), 2);
        #2;
        i_Rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst.lives", 32'(lif.o_Lives), 3);
        chk("async_rst.wins", 32'(lif.o_Wins), 0);
        chk("async_rst.freeze", 32'(lif.o_Freeze), 1);
        chk_model("async_rst");
        @(negedge i_Clk);
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        step("post_rst", 0, 0, 0);

        // Randomized play against the model
        for (int i = 0; i < 600; i++) begin
            logic s, c, g;
            s = ($urandom_range(0, 19) == 0);
            c = ($urandom_range(0, 9) == 0);
            g = ($urandom_range(0, 4) == 0);
            if (!m_active && $urandom_range(0, 3) == 0) s = 1'b1;
            step("rand", s, c, g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frogger_life_manager.md
# frogger_life_manager

Game-state and life-accounting stage directly downstream of the collision detector. It consumes the registered collision flag and a goal-reached pulse, and owns the authoritative life count. It sequences death → freeze → respawn → grace period, and detects game over. It drives the frog movement block (respawn/freeze), the display (lives, wins, game-over) and the top-level start/restart flow.

## Interface
Parameters:
- LIVES_INIT, 3, lives loaded at reset and on every start; legal 1..3
- RESPAWN_CYCLES, 25_000_000, cycles the frog is frozen after a hit; ≥1
- GRACE_CYCLES, 50_000_000, post-respawn invulnerability cycles; ≥1

Ports:
- i_Clk  in  1  system clock
- i_Rst_n  in  1  reset, asynchronous assert, active-low
- i_Start  in  1  start/restart request, 1-cycle pulse
- i_Collided  in  1  collision flag from the collision stage (level)
- i_Goal_Reached  in  1  frog entered the goal row, 1-cycle pulse
- o_Lives  out  2  remaining lives
- o_Wins  out  4  goals reached this game, saturating
- o_Respawn  out  1  1-cycle pulse: frog mover reloads origin coordinates
- o_Freeze  out  1  frog movement inputs must be ignored
- o_Invulnerable  out  1  grace period active (display may blink the frog)
- o_Game_Over  out  1  game-over state

## Operation
- States: IDLE, PLAY, DYING, GRACE, GAME_OVER. Single down-counter, width $clog2(max(RESPAWN_CYCLES,GRACE_CYCLES)); shared by DYING and GRACE.
- Reset values:
  - state = IDLE
  - o_Lives = LIVES_INIT
  - o_Freeze = 1
  - o_Wins, o_Respawn, o_Invulnerable, o_Game_Over = 0
  - counter = 0
- IDLE: o_Freeze=1. i_Start → PLAY; reload o_Lives=LIVES_INIT; clear o_Wins; pulse o_Respawn.
- PLAY: o_Freeze=0.
  - i_Collided=1 while o_Lives>1 → decrement lives, counter=RESPAWN_CYCLES-1, go to DYING.
  - i_Collided=1 while o_Lives=1 → o_Lives=0, go to GAME_OVER.
  - i_Goal_Reached=1 and i_Collided=0 → o_Wins+1 (saturate at 15), pulse o_Respawn, stay in PLAY.
  - Collision and goal in the same cycle: the collision wins and the goal is discarded.
- DYING: o_Freeze=1; i_Collided and i_Goal_Reached ignored. Counter decrements each cycle. At counter=0 → GRACE, counter=GRACE_CYCLES-1, pulse o_Respawn.
- GRACE: o_Invulnerable=1, o_Freeze=0; i_Collided ignored; goals count as in PLAY. At counter=0 → PLAY.
- GAME_OVER: o_Game_Over=1, o_Freeze=1, o_Lives=0. i_Start → same actions as from IDLE.
- i_Start in PLAY/DYING/GRACE is ignored.
- Lives never underflow; o_Lives=0 only in GAME_OVER.
- Reset assertion mid-game, in any state, returns immediately to reset values.

## Timing
- All outputs are registered; no combinational path from input to output.
- Input sampled at edge N: resulting o_Lives, state flags and o_Respawn are visible after edge N (i.e. during cycle N+1).
- i_Collided is itself one cycle late relative to frog/car positions; no compensation is applied here.
- DYING lasts exactly RESPAWN_CYCLES cycles. o_Respawn is high during the first GRACE cycle only. GRACE lasts exactly GRACE_CYCLES cycles.
- A collision held high across the GRACE→PLAY boundary causes a hit on the first PLAY cycle (level-sensitive by design).
- o_Respawn is never high for 2 consecutive cycles.

## Test plan
Bench uses LIVES_INIT=3, RESPAWN_CYCLES=4, GRACE_CYCLES=6.
- Reset → IDLE, o_Lives=3, o_Freeze=1. Pulse i_Start → next cycle o_Respawn=1, o_Freeze=0, o_Wins=0.
- In PLAY, hold i_Collided for 1 cycle → o_Lives=2 and o_Freeze=1 for exactly 4 cycles. Then o_Respawn=1 for 1 cycle and o_Invulnerable=1 for 6 cycles. A collision during grace leaves o_Lives=2.
- Three hits, each separated by full recovery → o_Lives steps 2,1,0; after the third hit o_Game_Over=1. i_Start → o_Lives=3, o_Wins=0, o_Game_Over=0.
- Same-cycle i_Collided and i_Goal_Reached in PLAY → o_Lives decrements, o_Wins unchanged. 17 clean goals → o_Wins saturates at 15, with one o_Respawn pulse per goal.
- Deassert i_Rst_n asynchronously mid-DYING (counter=2) → all outputs take reset values before the next clock edge; i_Start during DYING has no effect.
